// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 absorb path: FSM states, standard
// rate widths and the padding bytes.
package sha3_pkg;

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_t;

  localparam int RATE_SHA3_224 = 1152;
  localparam int RATE_SHA3_256 = 1088;
  localparam int RATE_SHA3_384 = 832;
  localparam int RATE_SHA3_512 = 576;

  localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
  localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_END      = 8'h80;

endpackage

// File: rtl/sha3_keep_count.sv
// Byte-enable analysis: number of set TKEEP bits and whether they form a
// contiguous run starting at bit 0.
module sha3_keep_count #(
  parameter int KW = 2,
  parameter int CW = $clog2(KW + 1)
) (
  input  logic [KW-1:0] keep,
  output logic [CW-1:0] count,
  output logic          contiguous
);

  logic [KW:0] keep_ext;
  logic [KW:0] keep_inc;

  // Population count of the byte enables.
  always_comb begin
    count = '0;
    for (int i = 0; i < KW; i++) begin
      count = count + CW'(keep[i]);
    end
  end

  // A run of ones from bit 0 plus one leaves no bit in common with itself.
  always_comb begin
    keep_ext   = {1'b0, keep};
    keep_inc   = keep_ext + {{KW{1'b0}}, 1'b1};
    contiguous = ((keep_inc & keep_ext) == '0);
  end

endmodule

// File: rtl/sha3_absorb_packer.sv
// Packs message beats into one Keccak rate block, applies SHA-3 pad10*1 with the
// domain byte, and hands blocks on over valid/ready. Optional macro: SHA3_KEEP_CHECK_EN.
module sha3_absorb_packer
  import sha3_pkg::*;
#(
  parameter int         DATA_WIDTH = 16,
  parameter int         RATE_BITS  = RATE_SHA3_256,
  parameter logic [7:0] DOMAIN     = DOMAIN_SHA3
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [DATA_WIDTH-1:0]   S_TDATA,
  input  logic                    S_TVALID,
  input  logic                    S_TLAST,
  input  logic [DATA_WIDTH/8-1:0] S_TKEEP,
  output logic                    S_TREADY,
  output logic [RATE_BITS-1:0]    blk_data,
  output logic                    blk_valid,
  output logic                    blk_last,
  input  logic                    blk_ready,
  output logic                    err_keep
);

  localparam int KW  = DATA_WIDTH / 8;
  localparam int CW  = $clog2(KW + 1);
  localparam int WPB = RATE_BITS / DATA_WIDTH;
  localparam int RB  = RATE_BITS / 8;
  localparam int WW  = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int PW  = $clog2(RB + 1);

  localparam logic [WW-1:0] LAST_WORD = WW'(WPB - 1);

  state_t                  state;
  state_t                  state_next;
  logic [WW-1:0]           word_ptr;
  logic [RATE_BITS-1:0]    buffer;
  logic                    pend_pad;
  logic                    beat_acc;
  logic [CW-1:0]           keep_cnt;
  logic                    keep_contig;
  logic [PW-1:0]           pos;
  logic [DATA_WIDTH-1:0]   masked;
  logic [RATE_BITS-1:0]    pad_xor;
  logic [RATE_BITS-1:0]    fill_buf;
  logic [RATE_BITS-1:0]    pad_only;

  sha3_keep_count #(
    .KW (KW),
    .CW (CW)
  ) u_keep_count (
    .keep       (S_TKEEP),
    .count      (keep_cnt),
    .contiguous (keep_contig)
  );

  assign S_TREADY  = (state == FILL) && !ARESET;
  assign beat_acc  = S_TVALID && S_TREADY;
  assign blk_valid = (state == OUT);
  assign blk_data  = buffer;
  assign pos       = PW'(word_ptr) * PW'(KW) + PW'(keep_cnt);

  // Disabled bytes are stored as zero so padding can be XORed in unconditionally.
  always_comb begin
    masked = '0;
    for (int i = 0; i < KW; i++) begin
      masked[i*8 +: 8] = S_TKEEP[i] ? S_TDATA[i*8 +: 8] : 8'h00;
    end
  end

  // Padding pattern for a final beat that leaves room for at least one pad byte.
  always_comb begin
    pad_xor = '0;
    if (S_TLAST && (pos < PW'(RB))) begin
      pad_xor[int'(pos)*8 +: 8]    = DOMAIN;
      pad_xor[RATE_BITS-8 +: 8]    = pad_xor[RATE_BITS-8 +: 8] ^ PAD_END;
    end else begin
      pad_xor = '0;
    end
  end

  // Buffer content after accepting the current beat.
  always_comb begin
    fill_buf = buffer;
    fill_buf[int'(word_ptr)*DATA_WIDTH +: DATA_WIDTH] = masked;
    fill_buf = fill_buf ^ pad_xor;
  end

  // Block emitted after an exactly rate-aligned message: padding only.
  always_comb begin
    pad_only                     = '0;
    pad_only[7:0]                = DOMAIN;
    pad_only[RATE_BITS-8 +: 8]   = pad_only[RATE_BITS-8 +: 8] ^ PAD_END;
  end

  // State register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (beat_acc && (S_TLAST || (word_ptr == LAST_WORD))) begin
          state_next = OUT;
        end else begin
          state_next = FILL;
        end
      end
      OUT: begin
        if (blk_ready && !pend_pad) begin
          state_next = FILL;
        end else begin
          state_next = OUT;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Block buffer, word pointer, final-block tag and pending pad-only block.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      word_ptr <= '0;
      buffer   <= '0;
      pend_pad <= 1'b0;
      blk_last <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (beat_acc) begin
            buffer <= fill_buf;
            if (S_TLAST) begin
              word_ptr <= '0;
              if (pos < PW'(RB)) begin
                blk_last <= 1'b1;
              end else begin
                blk_last <= 1'b0;
                pend_pad <= 1'b1;
              end
            end else if (word_ptr == LAST_WORD) begin
              word_ptr <= '0;
              blk_last <= 1'b0;
            end else begin
              word_ptr <= word_ptr + WW'(1);
            end
          end
        end
        OUT: begin
          if (blk_ready) begin
            if (pend_pad) begin
              buffer   <= pad_only;
              blk_last <= 1'b1;
              pend_pad <= 1'b0;
            end else begin
              buffer   <= '0;
              word_ptr <= '0;
              blk_last <= 1'b0;
            end
          end
        end
        default: begin
          word_ptr <= '0;
          buffer   <= '0;
          pend_pad <= 1'b0;
          blk_last <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHA3_KEEP_CHECK_EN
  // Sticky flag for gaps in TKEEP or a partial beat that is not the last one.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_keep <= 1'b0;
    end else if (beat_acc && (!keep_contig || (!S_TLAST && (S_TKEEP != {KW{1'b1}})))) begin
      err_keep <= 1'b1;
    end
  end
`else
  logic unused_keep_contig;
  assign unused_keep_contig = keep_contig;
  assign err_keep           = 1'b0;
`endif

endmodule
